// File: rtl/serial_tx.sv
// serial_tx: UART-style serializer with a valid/ready word input, optional parity and 1-2 stop bits.
// All outputs are registered; the line idles high.
module serial_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic                  tx,
    output logic                  busy
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_n;
    logic [BW-1:0]         baud, baud_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [DATA_WIDTH-1:0] shift, shift_n;
    logic                  par, par_n;
    logic                  tx_n, busy_n, ready_n;
    logic                  bit_end;

    always_comb begin
        bit_end = baud == BW'(CLKS_PER_BIT - 1);
        state_n = state;
        baud_n  = bit_end ? '0 : baud + 1'b1;
        cnt_n   = cnt;
        shift_n = shift;
        par_n   = par;
        tx_n    = tx;
        busy_n  = busy;
        ready_n = data_in_ready;
        case (state)
            IDLE: begin
                baud_n  = '0;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
                ready_n = 1'b1;
                if (data_in_valid && data_in_ready) begin
                    shift_n = data_in;
                    par_n   = (^data_in) ^ (PARITY_ODD != 0);
                    state_n = START;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                    ready_n = 1'b0;
                end
            end
            START: if (bit_end) begin
                state_n = DATA;
                cnt_n   = '0;
                tx_n    = shift[0];
            end
            DATA: if (bit_end) begin
                // the next bit is presented from the shift register before it moves
                shift_n = shift >> 1;
                tx_n    = shift[1];
                cnt_n   = cnt + 1'b1;
                if (cnt == CW'(DATA_WIDTH - 1)) begin
                    cnt_n   = '0;
                    state_n = (PARITY_EN != 0) ? PARITY : STOP;
                    tx_n    = (PARITY_EN != 0) ? par : 1'b1;
                end
            end
            PARITY: if (bit_end) begin
                state_n = STOP;
                tx_n    = 1'b1;
            end
            STOP: if (bit_end) begin
                cnt_n = cnt + 1'b1;
                if (cnt == CW'(STOP_BITS - 1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    busy_n  = 1'b0;
                    ready_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        shift <= shift_n;
        if (rst) begin
            state         <= IDLE;
            baud          <= '0;
            cnt           <= '0;
            par           <= 1'b0;
            tx            <= 1'b1;
            busy          <= 1'b0;
            data_in_ready <= 1'b0;
        end else begin
            state         <= state_n;
            baud          <= baud_n;
            cnt           <= cnt_n;
            par           <= par_n;
            tx            <= tx_n;
            busy          <= busy_n;
            data_in_ready <= ready_n;
        end
    end
endmodule
